// File: rtl/jam_param.sv
// Exhaustive job-assignment engine: walks all N! worker-to-job permutations in
// lexicographic order and reports the best total cost, its multiplicity and first permutation.
module jam_param #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int IDX_W  = 3,
  parameter int SUM_W  = 10,
  parameter int MC_W   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic                  Mode,
  output logic [IDX_W-1:0]      W,
  output logic [IDX_W-1:0]      J,
  input  logic [COST_W-1:0]     Cost,
  output logic                  Busy,
  output logic                  Valid,
  output logic [SUM_W-1:0]      BestCost,
  output logic [MC_W-1:0]       MatchCount,
  output logic [N*IDX_W-1:0]    BestPerm
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] k;
  logic [SUM_W-1:0] sum;
  logic             mode_r;
  logic             first_flag;
  logic [IDX_W-1:0] perm      [N];
  logic [IDX_W-1:0] best_perm [N];

  // Next-permutation network
  logic [IDX_W-1:0] perm_nxt  [N];
  logic [IDX_W-1:0] swp       [N];
  logic [IDX_W-1:0] piv;
  logic [IDX_W-1:0] succ;
  logic [IDX_W-1:0] rev;
  logic             found;
  logic             is_last;

  function automatic logic [MC_W-1:0] sat_inc(input logic [MC_W-1:0] v);
    return (&v) ? v : v + MC_W'(1);
  endfunction

  function automatic logic improves(input logic             maximise,
                                    input logic [SUM_W-1:0] cand,
                                    input logic [SUM_W-1:0] best);
    return maximise ? (cand > best) : (cand < best);
  endfunction

  always_comb begin
    piv   = '0;
    succ  = '0;
    rev   = '0;
    found = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm[i] < perm[i+1]) begin
        piv   = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if ((IDX_W'(j) > piv) && (perm[j] > perm[piv])) succ = IDX_W'(j);
    end
    for (int m = 0; m < N; m++) swp[m] = perm[m];
    swp[piv]  = perm[succ];
    swp[succ] = perm[piv];
    // Suffix after the pivot is descending; reversing it gives the smallest tail.
    for (int m = 0; m < N; m++) begin
      perm_nxt[m] = swp[m];
      if (IDX_W'(m) > piv) begin
        rev         = piv + IDX_W'(N - m);
        perm_nxt[m] = swp[rev];
      end
    end
  end

  assign is_last = ~found;

  always_comb begin
    state_nxt = state;
    W         = '0;
    J         = '0;
    Busy      = 1'b0;
    Valid     = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        Busy = 1'b1;
        W    = k;
        J    = perm[k];
        if (k == K_LAST) state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        Busy      = 1'b1;
        state_nxt = is_last ? S_DONE : S_ACCUM;
      end
      S_DONE: begin
        Valid     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      k          <= '0;
      sum        <= '0;
      mode_r     <= 1'b0;
      first_flag <= 1'b0;
      BestCost   <= '0;
      MatchCount <= '0;
      for (int m = 0; m < N; m++) begin
        perm[m]      <= IDX_W'(m);
        best_perm[m] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (Start) begin
            mode_r     <= Mode;
            sum        <= '0;
            k          <= '0;
            first_flag <= 1'b1;
            BestCost   <= '0;
            MatchCount <= '0;
            for (int m = 0; m < N; m++) begin
              perm[m]      <= IDX_W'(m);
              best_perm[m] <= '0;
            end
          end
        end
        S_ACCUM: begin
          sum <= sum + SUM_W'(Cost);
          if (k != K_LAST) k <= k + IDX_W'(1);
        end
        S_UPDATE: begin
          // Strict improvement only, so ties keep the earlier permutation.
          if (first_flag || improves(mode_r, sum, BestCost)) begin
            BestCost   <= sum;
            MatchCount <= MC_W'(1);
            first_flag <= 1'b0;
            for (int m = 0; m < N; m++) best_perm[m] <= perm[m];
          end else if (sum == BestCost) begin
            MatchCount <= sat_inc(MatchCount);
          end
          if (!is_last) begin
            for (int m = 0; m < N; m++) perm[m] <= perm_nxt[m];
            sum <= '0;
            k   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign BestPerm[g*IDX_W +: IDX_W] = best_perm[g];
  end

endmodule

// File: tb/tb_jam_param.sv
// Directed bench for jam_param: N=3 and N=4 instances plus a narrow MatchCount
// instance, each fed by a combinational cost table.
module tb_jam_param;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int range_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // N=3 instance, cost[w][j] = (w+1)*(j+1)
  logic       start3 = 1'b0, mode3 = 1'b0;
  logic [1:0] w3, j3;
  logic [3:0] cost3;
  logic       busy3, valid3;
  logic [5:0] best3;
  logic [15:0] mc3;
  logic [5:0] perm3;

  always_comb cost3 = 4'((int'(w3) + 1) * (int'(j3) + 1));

  jam_param #(.N(3), .COST_W(4), .IDX_W(2), .SUM_W(6), .MC_W(16)) u3 (
    .CLK(CLK), .RST(RST), .Start(start3), .Mode(mode3), .W(w3), .J(j3), .Cost(cost3),
    .Busy(busy3), .Valid(valid3), .BestCost(best3), .MatchCount(mc3), .BestPerm(perm3));

  // N=4 instance, table 0: |w-j|, table 1: 0 on j==(w+1)%4 else 5
  logic       start4 = 1'b0, mode4 = 1'b0;
  int         sel4 = 0;
  logic [1:0] w4, j4, wn4;
  logic [6:0] cost4;
  logic       busy4, valid4;
  logic [9:0] best4;
  logic [15:0] mc4;
  logic [7:0] perm4;

  always_comb begin
    wn4   = w4 + 2'd1;
    cost4 = '0;
    if (sel4 == 0) cost4 = (w4 > j4) ? 7'(w4 - j4) : 7'(j4 - w4);
    else           cost4 = (j4 == wn4) ? 7'd0 : 7'd5;
  end

  jam_param #(.N(4), .COST_W(7), .IDX_W(2), .SUM_W(10), .MC_W(16)) u4 (
    .CLK(CLK), .RST(RST), .Start(start4), .Mode(mode4), .W(w4), .J(j4), .Cost(cost4),
    .Busy(busy4), .Valid(valid4), .BestCost(best4), .MatchCount(mc4), .BestPerm(perm4));

  // N=4 instance with 4-bit MatchCount, all costs 3
  logic       start4s = 1'b0;
  logic [1:0] w4s, j4s;
  logic       busy4s, valid4s;
  logic [9:0] best4s;
  logic [3:0] mc4s;
  logic [7:0] perm4s;

  jam_param #(.N(4), .COST_W(7), .IDX_W(2), .SUM_W(10), .MC_W(4)) u4s (
    .CLK(CLK), .RST(RST), .Start(start4s), .Mode(1'b0), .W(w4s), .J(j4s), .Cost(7'd3),
    .Busy(busy4s), .Valid(valid4s), .BestCost(best4s), .MatchCount(mc4s), .BestPerm(perm4s));

  always @(negedge CLK) if (w3 >= 2'd3 || j3 >= 2'd3) range_err++;

  task automatic run3(input logic m, input int ec, input int emc, input int ep);
    int n;
    mode3 = m; start3 = 1'b1;
    @(posedge CLK); #1; start3 = 1'b0;
    check("n3_busy_after_start", busy3, 1);
    n = 0;
    while (!valid3 && n < 200) begin
      n++;
      @(posedge CLK); #1;
    end
    check("n3_latency", n, 24);
    check("n3_bestcost", best3, ec);
    check("n3_matchcount", mc3, emc);
    check("n3_bestperm", perm3, ep);
    check("n3_busy_in_done", busy3, 0);
    @(posedge CLK); #1;
    check("n3_valid_one_cycle", valid3, 0);
  endtask

  task automatic run4(input logic m, input int sel, input int ec, input int emc, input int ep);
    int n;
    sel4 = sel; mode4 = m; start4 = 1'b1;
    @(posedge CLK); #1; start4 = 1'b0;
    check("n4_busy_after_start", busy4, 1);
    check("n4_cleared_at_start", best4, 0);
    n = 0;
    while (!valid4 && n < 400) begin
      n++;
      start4 = (n == 7 || n == 60);
      @(posedge CLK); #1;
    end
    start4 = 1'b0;
    check("n4_latency", n, 120);
    check("n4_bestcost", best4, ec);
    check("n4_matchcount", mc4, emc);
    check("n4_bestperm", perm4, ep);
    start4 = 1'b1;
    @(posedge CLK); #1; start4 = 1'b0;
    check("n4_start_in_done_ignored", busy4, 0);
    check("n4_valid_one_cycle", valid4, 0);
    check("n4_results_stable", best4, ec);
  endtask

  initial begin
    int n;
    int vcount;
    @(posedge CLK); @(posedge CLK); #1;
    check("rst_busy", busy3, 0);
    check("rst_valid", valid3, 0);
    check("rst_wj", {w3, j3}, 0);
    check("rst_bestcost", best3, 0);
    check("rst_matchcount", mc3, 0);
    check("rst_bestperm", perm3, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run3(1'b0, 10, 1, 6'h06);
    run3(1'b1, 14, 1, 6'h24);

    run4(1'b0, 0, 0, 1, 8'hE4);
    run4(1'b0, 1, 0, 1, 8'h39);
    run4(1'b1, 0, 8, 4, 8'h4E);

    // Abort a run with reset
    sel4 = 1; mode4 = 1'b1; start4 = 1'b1;
    @(posedge CLK); #1; start4 = 1'b0;
    repeat (30) begin @(posedge CLK); #1; end
    check("mid_busy_before_rst", busy4, 1);
    RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    check("mid_rst_busy", busy4, 0);
    check("mid_rst_valid", valid4, 0);
    check("mid_rst_wj", {w4, j4}, 0);
    check("mid_rst_bestcost", best4, 0);
    check("mid_rst_matchcount", mc4, 0);
    check("mid_rst_bestperm", perm4, 0);
    vcount = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge CLK); #1;
      if (valid4) vcount++;
    end
    check("mid_rst_no_valid", vcount, 0);
    run4(1'b1, 1, 20, 9, 8'hE4);

    // Saturating MatchCount
    start4s = 1'b1;
    @(posedge CLK); #1; start4s = 1'b0;
    n = 0;
    while (!valid4s && n < 400) begin
      n++;
      @(posedge CLK); #1;
    end
    check("sat_latency", n, 120);
    check("sat_bestcost", best4s, 12);
    check("sat_matchcount", mc4s, 15);
    check("sat_bestperm", perm4s, 8'hE4);

    check("wj_range", range_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jam_param.md
Name: jam_param

Overview:
- Parametrised exhaustive job-assignment engine; successor to the fixed 8x8 JAM block.
- Enumerates all N! worker-to-job permutations in lexicographic order and fetches each cost from an external combinational cost ROM via W/J.
- Reports the optimal total cost, the number of permutations that reach it, and the first optimal permutation.
- Adds over the fixed block:
  - Start/Busy handshake for back-to-back problems.
  - Min/max optimisation mode.
  - Best-permutation output.

Parameters:
N, 8, number of workers = number of jobs (legal 2..8)
COST_W, 7, width of one cost entry
IDX_W, 3, width of W/J index; must satisfy 2**IDX_W >= N
SUM_W, 10, width of accumulated cost; must satisfy SUM_W >= COST_W + ceil(log2 N)
MC_W, 16, width of MatchCount; saturates at all-ones

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-high
Start  input  1  begin a new problem; sampled only in IDLE
Mode  input  1  0 = minimise, 1 = maximise; sampled with Start
W  output  IDX_W  worker index to cost ROM
J  output  IDX_W  job index to cost ROM
Cost  input  COST_W  cost[W][J]; combinational, valid in the same cycle as W/J
Busy  output  1  high from the cycle after Start is accepted until Valid
Valid  output  1  one-cycle pulse: results final
BestCost  output  SUM_W  optimal total cost
MatchCount  output  MC_W  number of permutations with cost == BestCost
BestPerm  output  N*IDX_W  job of worker k in bits [k*IDX_W +: IDX_W]; first optimum found in lexicographic order

Behaviour:
- Reset (RST high at a rising edge):
  - State goes to IDLE.
  - Busy, Valid, W, J, BestCost, MatchCount and BestPerm all reset to 0.
  - Internal perm is set to identity (perm[k] = k).
  - Reset overrides any in-progress run; no Valid is produced for an aborted run.
- States: IDLE, ACCUM, UPDATE, DONE.
- IDLE:
  - W = J = 0.
  - Start = 1 latches Mode, clears sum and k, sets perm to identity, sets first_flag, and enters ACCUM.
  - BestCost, MatchCount and BestPerm hold the previous results until that edge, then clear to 0.
- ACCUM, for k = 0..N-1:
  - W = k and J = perm[k] are driven registered-free from the state.
  - sum += Cost at each edge, zero-extended to SUM_W.
  - After k = N-1 the state goes to UPDATE.
- UPDATE (1 cycle):
  - If first_flag, or (Mode = 0 and sum < best), or (Mode = 1 and sum > best): best = sum, MatchCount = 1, BestPerm = perm, first_flag clears.
  - Else if sum == best: MatchCount += 1, saturating at 2**MC_W - 1.
  - If perm is strictly descending (last permutation), the state goes to DONE.
  - Otherwise perm = lexicographic next permutation, computed in this single cycle: largest i with perm[i] < perm[i+1]; largest j with perm[j] > perm[i]; swap them; reverse the suffix after i. Then sum and k clear and the state returns to ACCUM.
- Ties keep the earlier BestPerm.
- DONE:
  - Valid = 1 and Busy = 0 for exactly one cycle; the state then returns to IDLE.
  - Results stay stable until the next accepted Start or RST.
- Latency: each permutation takes N+1 cycles. Valid is high in the cycle after rising edge number N!*(N+1) counted from the edge that sampled Start (N=8: 362880; N=3: 24).
- Start while Busy, or in the DONE cycle, is ignored. Start in the cycle after the Valid pulse is accepted.
- Only the lower N indices are ever driven on W/J; W and J never reach N or above.

Test Plan:
- N=8, Mode=0, cost[w][j] = 1 except cost[w][w] = 0 → BestCost=0, MatchCount=1, BestPerm = identity, Valid in cycle 362880 after Start.
- N=8, all costs = 5, Mode=0 → BestCost=40, MatchCount=40320, BestPerm = identity; repeat with Mode=1 → same values.
- N=3 instance, costs {{1,2,3},{2,4,6},{3,6,9}}:
  - Mode=0 → BestCost=10, MatchCount=1, BestPerm={2,1,0}.
  - Mode=1 → BestCost=14, MatchCount=1, BestPerm = identity.
  - Valid in cycle 24 after Start.
- Two back-to-back problems on N=4 with different tables; Start pulses during Busy are ignored; each run gives its own correct Valid and results.
- RST asserted mid-run → all outputs 0 next cycle, no Valid; a following Start completes with correct results.
- MC_W=4, N=4, all costs equal → MatchCount saturates at 15 (true count 24).
